// File: rtl/bmem_responder.sv
// Line-based memory responder: 256-bit lines, 4-beat 64-bit read responses and write bursts.
// Optional BMEM_STALL_EN adds an LFSR that randomly deasserts bmem_ready.
module bmem_responder #(
  parameter int LINES        = 256,
  parameter int READ_LATENCY = 4,
  parameter int QDEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
);
  localparam int IW = $clog2(LINES);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = 16;

  logic [255:0]    mem [LINES];
  logic [31:0]     q_addr [QDEPTH];
  logic [TW-1:0]   q_ts [QDEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   now;
  logic [TW-1:0]   age;
  logic            stall, rd_acc, wr_acc, start, pop;
  logic [1:0]      wbeat;
  logic [IW-1:0]   widx;
  logic [191:0]    stage;
  logic            rv_q;
  logic [1:0]      rbeat;
  logic [31:0]     raddr_q;
  logic [255:0]    line_q, line_now;

`ifdef BMEM_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // A request transfers on a cycle where bmem_ready is high together with bmem_read or
  // bmem_write; write wins a tie, and reads are refused while a write burst is mid-flight.
  assign bmem_ready = (count != CW'(QDEPTH)) && !rst && !stall;
  assign wr_acc     = bmem_write && bmem_ready;
  assign rd_acc     = bmem_read && bmem_ready && !bmem_write && (wbeat == 2'd0);

  // The head entry stays queued through its first beat so a full queue holds ready low until then.
  assign pop   = rv_q && (rbeat == 2'd0);
  assign age   = now - q_ts[rd_ptr];
  assign start = (!rv_q || (rbeat == 2'd3)) && (count != '0) &&
                 (age >= TW'(READ_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      now    <= '0;
    end else begin
      now <= now + 1'b1;
      if (rd_acc) wr_ptr <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)    rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(rd_acc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      q_addr[wr_ptr] <= bmem_addr;
      q_ts[wr_ptr]   <= now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q    <= 1'b0;
      rbeat   <= 2'd0;
      raddr_q <= '0;
    end else if (start) begin
      rv_q    <= 1'b1;
      rbeat   <= 2'd0;
      raddr_q <= q_addr[rd_ptr];
    end else if (rv_q) begin
      rbeat <= rbeat + 2'd1;
      if (rbeat == 2'd3) rv_q <= 1'b0;
    end
  end

  // Line is sampled straight from storage on the first beat and held for beats 1-3.
  assign line_now = mem[raddr_q[5 +: IW]];

  always_ff @(posedge clk) begin
    if (pop) line_q <= line_now;
  end

  always_comb begin
    bmem_rvalid = rv_q && !rst;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    if (bmem_rvalid) begin
      bmem_raddr = raddr_q;
      bmem_rdata = (rbeat == 2'd0) ? line_now[63:0] : line_q[{rbeat, 6'b0} +: 64];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbeat <= 2'd0;
      widx  <= '0;
      stage <= '0;
    end else if (wr_acc) begin
      wbeat <= wbeat + 2'd1;
      case (wbeat)
        2'd0: begin
          widx         <= bmem_addr[5 +: IW];
          stage[63:0]  <= bmem_wdata;
        end
        2'd1:    stage[127:64]  <= bmem_wdata;
        2'd2:    stage[191:128] <= bmem_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && (wbeat == 2'd3)) mem[widx] <= {bmem_wdata, stage};
  end
endmodule

// File: tb/tb_bmem_responder.sv
// Directed bench for bmem_responder: write/read round trips, queueing, collisions, reset aborts.
// Define BMEM_STALL_EN to exercise the ready-stall build instead of the cycle-exact ready checks.
module tb_bmem_responder;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  bmem_responder #(.LINES(256), .READ_LATENCY(RL), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic write_line(input logic [31:0] addr, input logic [255:0] line,
                            input logic with_read, input string name);
    int guard;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bmem_write = 1'b1;
      bmem_read  = with_read;
      bmem_wdata = line[64*k +: 64];
      bmem_addr  = (k == 0) ? addr : (addr ^ 32'h0000_0F00);
      #1;
      guard = 0;
      while (!bmem_ready && guard < 64) begin
        @(negedge clk); #1; guard++;
      end
      n_checks++;
      if (guard >= 64) begin
        n_fail++;
        $display("FAIL %s_wr_ready: got ready=%0b after %0d cycles expected ready=1", name, bmem_ready, guard);
      end
    end
    @(negedge clk);
    bmem_write = 1'b0;
    bmem_read  = 1'b0;
  endtask

  task automatic read_check(input logic [31:0] addr, input logic [255:0] line, input string name);
    int guard;
    int lat;
    @(negedge clk);
    bmem_read = 1'b1;
    bmem_addr = addr;
    #1;
    guard = 0;
    while (!bmem_ready && guard < 64) begin
      @(negedge clk); #1; guard++;
    end
    n_checks++;
    if (guard >= 64) begin
      n_fail++;
      $display("FAIL %s_accept: got no accept after %0d cycles expected accept", name, guard);
    end
    @(negedge clk);
    bmem_read = 1'b0;
    #1;
    lat = 1;
    while (!bmem_rvalid && lat < 64) begin
      @(negedge clk); #1; lat++;
    end
    n_checks++;
    if (lat != RL) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, RL);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      n_checks++;
      if (bmem_rvalid !== 1'b1 || bmem_rdata !== line[64*k +: 64] || bmem_raddr !== addr) begin
        n_fail++;
        $display("FAIL %s_beat%0d: got v=%0b d=%h a=%h expected v=1 d=%h a=%h",
                 name, k, bmem_rvalid, bmem_rdata, bmem_raddr, line[64*k +: 64], addr);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (bmem_rvalid !== 1'b0 || bmem_rdata !== 64'h0 || bmem_raddr !== 32'h0) begin
      n_fail++;
      $display("FAIL %s_idle: got v=%0b d=%h a=%h expected all 0", name, bmem_rvalid, bmem_rdata, bmem_raddr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (bmem_ready !== 1'b0 || bmem_rvalid !== 1'b0 || bmem_rdata !== 64'h0 || bmem_raddr !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_during: got r=%0b v=%0b d=%h a=%h expected all 0",
                 bmem_ready, bmem_rvalid, bmem_rdata, bmem_raddr);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bmem_rvalid !== 1'b0 || bmem_rdata !== 64'h0 || bmem_raddr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_after: got v=%0b d=%h a=%h expected all 0", bmem_rvalid, bmem_rdata, bmem_raddr);
    end
`ifndef BMEM_STALL_EN
    n_checks++;
    if (bmem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %0b expected 1", bmem_ready);
    end
`endif
  endtask

  task automatic test_write_read;
    logic [255:0] line;
    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    write_line(32'h0000_0040, line, 1'b0, "wr40");
    read_check(32'h0000_0040, line, "rd40");
  endtask

  task automatic test_unaligned;
    logic [255:0] line;
    line = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
            64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    write_line(32'h0000_0000, line, 1'b0, "wr00");
    read_check(32'h0000_001F, line, "rd1f");
  endtask

`ifndef BMEM_STALL_EN
  task automatic test_back_to_back;
    logic [255:0] lines [4];
    logic [31:0]  addrs [4];
    logic         exp_v;
    logic [63:0]  exp_d;
    logic [31:0]  exp_a;
    int           b;
    lines[0] = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    lines[1] = {64'hA1A1_A1A1_0000_0013, 64'hA1A1_A1A1_0000_0012,
                64'hA1A1_A1A1_0000_0011, 64'hA1A1_A1A1_0000_0010};
    lines[2] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    lines[3] = {64'hB3B3_B3B3_0000_0033, 64'hB3B3_B3B3_0000_0032,
                64'hB3B3_B3B3_0000_0031, 64'hB3B3_B3B3_0000_0030};
    addrs[0] = 32'h0000_0000;
    addrs[1] = 32'h0000_0020;
    addrs[2] = 32'h0000_0040;
    addrs[3] = 32'h0000_0060;
    write_line(addrs[1], lines[1], 1'b0, "wr20");
    write_line(addrs[3], lines[3], 1'b0, "wr60");
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bmem_read = (i < 5);
      bmem_addr = (i < 4) ? addrs[i] : 32'h0000_0080;
      #1;
      n_checks++;
      if (bmem_ready !== (i != 4)) begin
        n_fail++;
        $display("FAIL b2b_ready%0d: got %0b expected %0b", i, bmem_ready, (i != 4));
      end
      exp_v = (i >= 4) && (i < 20);
      exp_d = '0;
      exp_a = '0;
      if (exp_v) begin
        b     = i - 4;
        exp_d = lines[b / 4][64*(b % 4) +: 64];
        exp_a = addrs[b / 4];
      end
      n_checks++;
      if (bmem_rvalid !== exp_v || bmem_rdata !== exp_d || bmem_raddr !== exp_a) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v=%0b d=%h a=%h expected v=%0b d=%h a=%h",
                 i, bmem_rvalid, bmem_rdata, bmem_raddr, exp_v, exp_d, exp_a);
      end
    end
    bmem_read = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [255:0] old_line, new_line;
    old_line = {64'h0DD0_0000_0000_0003, 64'h0DD0_0000_0000_0002,
                64'h0DD0_0000_0000_0001, 64'h0DD0_0000_0000_0000};
    new_line = {64'hFEED_0000_0000_0003, 64'hFEED_0000_0000_0002,
                64'hFEED_0000_0000_0001, 64'hFEED_0000_0000_0000};
    write_line(32'h0000_00A0, old_line, 1'b0, "wra0");
    @(negedge clk);
    bmem_read = 1'b1;
    bmem_addr = 32'h0000_00A0;
    @(negedge clk);
    bmem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bmem_write = 1'b1;
      bmem_addr  = 32'h0000_00A0;
      bmem_wdata = new_line[64*k +: 64];
      #1;
      n_checks++;
      if (bmem_rvalid !== 1'b1 || bmem_rdata !== old_line[64*k +: 64]) begin
        n_fail++;
        $display("FAIL rstmid_beat%0d: got v=%0b d=%h expected v=1 d=%h",
                 k, bmem_rvalid, bmem_rdata, old_line[64*k +: 64]);
      end
    end
    @(negedge clk);
    rst        = 1'b1;
    bmem_wdata = new_line[128 +: 64];
    #1;
    n_checks++;
    if (bmem_rvalid !== 1'b0 || bmem_ready !== 1'b0 || bmem_rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL rstmid_during: got v=%0b r=%0b d=%h expected all 0", bmem_rvalid, bmem_ready, bmem_rdata);
    end
    @(negedge clk);
    rst        = 1'b0;
    bmem_write = 1'b0;
    #1;
    n_checks++;
    if (bmem_rvalid !== 1'b0 || bmem_rdata !== 64'h0 || bmem_raddr !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_after: got v=%0b d=%h a=%h expected all 0", bmem_rvalid, bmem_rdata, bmem_raddr);
    end
    read_check(32'h0000_00A0, old_line, "rstmid_old");
    write_line(32'h0000_00A0, new_line, 1'b0, "rstmid_wr");
    read_check(32'h0000_00A0, new_line, "rstmid_new");
  endtask
`endif

  task automatic test_rw_collide;
    logic [255:0] line;
    logic         saw;
    line = {64'hC0C0_0000_0000_0003, 64'hC0C0_0000_0000_0002,
            64'hC0C0_0000_0000_0001, 64'hC0C0_0000_0000_0000};
    write_line(32'h0000_0080, line, 1'b1, "collide");
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (bmem_rvalid !== 1'b0) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_no_rvalid: got rvalid seen=%0b expected 0", saw);
    end
    read_check(32'h0000_0080, line, "collide_rd");
  endtask

`ifdef BMEM_STALL_EN
  task automatic test_stall;
    logic [7:0]   m;
    logic [255:0] line;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m = 8'hA5;
    for (int i = 0; i < 24; i++) begin
      #1;
      n_checks++;
      if (bmem_ready !== !m[0]) begin
        n_fail++;
        $display("FAIL stall_ready%0d: got %0b expected %0b", i, bmem_ready, !m[0]);
      end
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
      @(negedge clk);
    end
    line = {64'h5757_0000_0000_0003, 64'h5757_0000_0000_0002,
            64'h5757_0000_0000_0001, 64'h5757_0000_0000_0000};
    write_line(32'h0000_00C0, line, 1'b0, "stall_wr");
    read_check(32'h0000_00C0, line, "stall_rd");
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_unaligned();
`ifndef BMEM_STALL_EN
    test_back_to_back();
`endif
    test_rw_collide();
`ifndef BMEM_STALL_EN
    test_reset_mid();
`else
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
